// File: rtl/fix_sqrt_seq_pkg.sv
// Shared fixed-point configuration for the sequential square-root block.
package fix_sqrt_seq_pkg;

    localparam int unsigned FIX_WIDTH = 32;
    localparam int unsigned FIX_FRAC  = 21;

    // Signed Q10.21 operand/result word
    typedef logic signed [FIX_WIDTH-1:0] fix_t;

endpackage

// File: rtl/fix_sqrt_seq_if.sv
// Operand/result handshake bundle for fix_sqrt_seq.
interface fix_sqrt_seq_if;
    import fix_sqrt_seq_pkg::*;

    logic in_valid;
    fix_t in_x;
    logic in_ready;
    logic out_valid;
    fix_t out_result;
    logic out_neg;
    logic out_ready;

    // Producer/consumer side
    modport master (
        output in_valid,
        output in_x,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_neg,
        output out_ready
    );

    // Square-root engine side
    modport slave (
        input  in_valid,
        input  in_x,
        output in_ready,
        output out_valid,
        output out_result,
        output out_neg,
        input  out_ready
    );

endinterface

// File: rtl/fix_sqrt_seq_sqrt_step.sv
// One restoring square-root iteration: consume two radicand bits, emit one root bit.
module sqrt_step #(
    parameter int unsigned ROOT_W = 27,
    parameter int unsigned REM_W  = 30
) (
    input  logic [REM_W-1:0]  i_rem,
    input  logic [ROOT_W-1:0] i_root,
    input  logic [1:0]        i_bits,
    output logic [REM_W-1:0]  o_rem,
    output logic [ROOT_W-1:0] o_root
);

    // Shifted remainder kept two bits wider so no stored bit is dropped
    localparam int unsigned SH_W = REM_W + 2;

    logic [SH_W-1:0] w_shift;
    logic [SH_W-1:0] w_trial;
    logic [SH_W-1:0] w_diff;
    logic            w_ge;

    // Compare against (root<<2)|1 and conditionally subtract
    always_comb begin
        w_shift = {i_rem, i_bits};
        w_trial = SH_W'({i_root, 2'b01});
        w_ge    = (w_shift >= w_trial);
        w_diff  = w_ge ? (w_shift - w_trial) : w_shift;
        o_rem   = REM_W'(w_diff);
        o_root  = {i_root[ROOT_W-2:0], w_ge};
    end

endmodule

// File: rtl/fix_sqrt_seq.sv
// Sequential Q10.21 floor square root, one result bit per clock.
module fix_sqrt_seq
    import fix_sqrt_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fix_sqrt_seq_if.slave bus
);

    localparam int unsigned SQRT_ITERS = 27;
    localparam int unsigned ROOT_W     = SQRT_ITERS;
    localparam int unsigned REM_W      = ROOT_W + 3;
    localparam int unsigned RAD_W      = 2 * SQRT_ITERS;
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [REM_W-1:0]  r_rem;
    logic [ROOT_W-1:0] r_root;
    logic [RAD_W-1:0]  r_rad;
    logic              r_neg_op;
    logic              r_in_ready;
    logic              r_out_valid;
    fix_t              r_out_result;
    logic              r_out_neg;

    logic [REM_W-1:0]  w_rem;
    logic [ROOT_W-1:0] w_root;

    // Single iteration datapath fed from the top two radicand bits
    sqrt_step #(
        .ROOT_W (ROOT_W),
        .REM_W  (REM_W)
    ) u_step (
        .i_rem  (r_rem),
        .i_root (r_root),
        .i_bits (r_rad[RAD_W-1 -: 2]),
        .o_rem  (w_rem),
        .o_root (w_root)
    );

    // Control FSM; outputs are published one clock after entering DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_rem        <= '0;
            r_root       <= '0;
            r_rad        <= '0;
            r_neg_op     <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_neg    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_cnt      <= '0;
                        r_rem      <= '0;
                        r_root     <= '0;
                        r_rad      <= RAD_W'({bus.in_x[FIX_WIDTH-2:0], {FIX_FRAC{1'b0}}});
                        r_neg_op   <= bus.in_x[FIX_WIDTH-1];
                        r_state    <= bus.in_x[FIX_WIDTH-1] ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem  <= w_rem;
                    r_root <= w_root;
                    r_rad  <= {r_rad[RAD_W-3:0], 2'b00};
                    if (r_cnt == CNT_W'(SQRT_ITERS - 1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid  <= 1'b1;
                        r_out_result <= r_neg_op ? '0 : FIX_WIDTH'(r_root);
                        r_out_neg    <= r_neg_op;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_neg    = r_out_neg;

endmodule

// File: tb/tb_fix_sqrt_seq.sv
// Directed and bounded-random checks for fix_sqrt_seq.
module tb_fix_sqrt_seq;
    import fix_sqrt_seq_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    fix_sqrt_seq_if bus ();

    fix_sqrt_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand and measure edges from accept to out_valid
    task automatic do_op(input fix_t x, output int lat, output fix_t res, output logic neg);
        int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 100) begin
            @(posedge clk); #1; w++;
        end
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        res = bus.out_result;
        neg = bus.out_neg;
    endtask

    // Consume the held result
    task automatic do_take();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_result !== 32'h0) $display("FAIL reset_out_result got=%h want=0", bus.out_result); else n_pass++;
        n_checks++; if (bus.out_neg !== 1'b0) $display("FAIL reset_out_neg got=%b want=0", bus.out_neg); else n_pass++;
    endtask

    task automatic test_directed();
        fix_t xs   [8] = '{32'h0020_0000, 32'h0080_0000, 32'h0040_0000, 32'h0010_0000,
                           32'h0120_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFE0_0000};
        fix_t exps [8] = '{32'h0020_0000, 32'h0040_0000, 32'h002D_413C, 32'h0016_A09E,
                           32'h0060_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        logic negs [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int   lats [8] = '{28, 28, 28, 28, 28, 28, 1, 1};
        int   lat;
        fix_t res;
        logic neg;
        for (int i = 0; i < 8; i++) begin
            do_op(xs[i], lat, res, neg);
            n_checks++; if (lat !== lats[i]) $display("FAIL dir_latency x=%h got=%0d want=%0d", xs[i], lat, lats[i]); else n_pass++;
            n_checks++; if (res !== exps[i]) $display("FAIL dir_result x=%h got=%h want=%h", xs[i], res, exps[i]); else n_pass++;
            n_checks++; if (neg !== negs[i]) $display("FAIL dir_neg x=%h got=%b want=%b", xs[i], neg, negs[i]); else n_pass++;
            do_take();
            n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL dir_drop_valid x=%h got=%b want=0", xs[i], bus.out_valid); else n_pass++;
            n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL dir_in_ready x=%h got=%b want=1", xs[i], bus.in_ready); else n_pass++;
        end
    endtask

    task automatic test_hold();
        int   lat;
        fix_t res;
        logic neg;
        do_op(32'h0080_0000, lat, res, neg);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL hold_valid cyc=%0d got=%b want=1", i, bus.out_valid); else n_pass++;
            n_checks++; if (bus.out_result !== 32'h0040_0000) $display("FAIL hold_result cyc=%0d got=%h want=00400000", i, bus.out_result); else n_pass++;
            n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL hold_in_ready cyc=%0d got=%b want=0", i, bus.in_ready); else n_pass++;
        end
        do_take();
    endtask

    task automatic test_ignore_in_valid();
        int lat;
        bus.in_valid = 1'b1;
        bus.in_x     = 32'h0020_0000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
            if (lat >= 3 && lat <= 6) begin
                n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL calc_in_ready lat=%0d got=%b want=0", lat, bus.in_ready); else n_pass++;
                bus.in_valid = 1'b1;
                bus.in_x     = 32'h8000_0000;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        n_checks++; if (lat !== 28) $display("FAIL ignore_latency got=%0d want=28", lat); else n_pass++;
        n_checks++; if (bus.out_result !== 32'h0020_0000) $display("FAIL ignore_result got=%h want=00200000", bus.out_result); else n_pass++;
        n_checks++; if (bus.out_neg !== 1'b0) $display("FAIL ignore_neg got=%b want=0", bus.out_neg); else n_pass++;
        do_take();
    endtask

    task automatic test_reset_mid_calc();
        int   lat;
        fix_t res;
        logic neg;
        bus.in_valid = 1'b1;
        bus.in_x     = 32'h0120_0000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL abort_out_valid got=%b want=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL abort_in_ready got=%b want=1", bus.in_ready); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL abort_discard got=%b want=0", bus.out_valid); else n_pass++;
        do_op(32'h0080_0000, lat, res, neg);
        n_checks++; if (lat !== 28) $display("FAIL abort_next_latency got=%0d want=28", lat); else n_pass++;
        n_checks++; if (res !== 32'h0040_0000) $display("FAIL abort_next_result got=%h want=00400000", res); else n_pass++;
        do_take();
    endtask

    task automatic test_back_to_back();
        int                lat;
        fix_t              res;
        fix_t              x;
        logic              neg;
        longint unsigned   rad;
        longint unsigned   r;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i == 0)      x = 32'h7FFF_FFFF;
            else if (i == 1) x = 32'h0000_0001;
            else if (i == 2) x = 32'h0000_0003;
            else             x = fix_t'($urandom & 32'h7FFF_FFFF);
            do_op(x, lat, res, neg);
            rad = longint'(x[30:0]) << FIX_FRAC;
            r   = longint'(unsigned'(res));
            n_checks++;
            if (!(r * r <= rad && rad < (r + 1) * (r + 1)) || neg !== 1'b0 || lat !== 28)
                $display("FAIL b2b_bound x=%h got=%h neg=%b lat=%0d want r*r<=%0d<(r+1)^2 neg=0 lat=28", x, res, neg, lat, rad);
            else
                n_pass++;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_directed();
        test_hold();
        test_ignore_in_valid();
        test_reset_mid_calc();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
